// File: rtl/cpu_issue_ctrl_if.sv
// Handshake and status bundle between decode, writeback and the issue controller.
// Signal suffixes are from the controller's point of view.
interface cpu_issue_ctrl_if;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [3:0]  rA_idx_i;
    logic        rA_use_i;
    logic [3:0]  rB_idx_i;
    logic        rB_use_i;
    logic [3:0]  wr_idx_i;
    logic        wr_en_i;
    logic        multi_i;
    logic        wb_en_i;
    logic [3:0]  wb_idx_i;
    logic        flush_i;
    logic        fire_o;
    logic        ex_stall_o;
    logic        hazard_o;
    logic [15:0] pending_o;
    logic        err_o;

    modport master (
        output issue_valid_i, rA_idx_i, rA_use_i, rB_idx_i, rB_use_i,
               wr_idx_i, wr_en_i, multi_i, wb_en_i, wb_idx_i, flush_i,
        input  issue_ready_o, fire_o, ex_stall_o, hazard_o, pending_o, err_o
    );

    modport slave (
        input  issue_valid_i, rA_idx_i, rA_use_i, rB_idx_i, rB_use_i,
               wr_idx_i, wr_en_i, multi_i, wb_en_i, wb_idx_i, flush_i,
        output issue_ready_o, fire_o, ex_stall_o, hazard_o, pending_o, err_o
    );
endinterface

// File: rtl/cpu_issue_ctrl.sv
// Issue/interlock controller: per-register in-flight write scoreboard, RAW/WAW
// interlock, multi-cycle op sequencing and the registered execute-stage stall.
module cpu_issue_ctrl #(
    parameter int MULTI_LAT = 4,
    parameter int CNT_W     = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    cpu_issue_ctrl_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        MULTI = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [3:0]       BUSY_INIT = 4'(MULTI_LAT - 1);

    state_t           r_state;
    state_t           w_stateNext;
    logic [3:0]       r_busy;
    logic [3:0]       w_busyNext;
    logic             r_exStall;
    logic             w_exStallNext;
    logic [3:0]       r_latIdx;
    logic [3:0]       w_latIdxNext;
    logic             r_latWr;
    logic             w_latWrNext;
    logic             r_err;
    logic             w_errSet;
    logic [CNT_W-1:0] r_cnt     [16];
    logic [CNT_W-1:0] w_cntNext [16];
    logic [CNT_W:0]   w_up      [16];
    logic [CNT_W:0]   w_down    [16];
    logic             w_hazard;
    logic             w_ready;
    logic             w_fire;
    logic             w_release;
    logic [15:0]      w_pending;

    assign w_hazard = (bus.rA_use_i && (r_cnt[bus.rA_idx_i] != '0))
                    | (bus.rB_use_i && (r_cnt[bus.rB_idx_i] != '0))
                    | (bus.wr_en_i  && (r_cnt[bus.wr_idx_i] == CNT_MAX));

    assign w_ready   = (r_state == IDLE) && !w_hazard && !bus.flush_i;
    assign w_fire    = bus.issue_valid_i && w_ready;
    assign w_release = bus.flush_i && (r_state == MULTI) && r_latWr;
    assign w_errSet  = bus.wb_en_i && (r_cnt[bus.wb_idx_i] == '0);

    assign bus.issue_ready_o = w_ready;
    assign bus.fire_o        = w_fire;
    assign bus.hazard_o      = bus.issue_valid_i && w_hazard;
    assign bus.ex_stall_o    = r_exStall;
    assign bus.err_o         = r_err;
    assign bus.pending_o     = w_pending;

    always_comb begin
        w_pending = '0;
        for (int r = 0; r < 16; r++) begin
            w_pending[r] = (r_cnt[r] != '0);
        end
    end

    // Flush overrides everything; execute stays busy (stall low) for the whole MULTI span.
    always_comb begin
        w_stateNext   = r_state;
        w_busyNext    = r_busy;
        w_exStallNext = 1'b1;
        w_latIdxNext  = r_latIdx;
        w_latWrNext   = r_latWr;
        if (bus.flush_i) begin
            w_stateNext   = IDLE;
            w_busyNext    = '0;
            w_exStallNext = 1'b1;
            w_latWrNext   = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_exStallNext = !w_fire;
                    if (w_fire && bus.multi_i) begin
                        w_stateNext  = MULTI;
                        w_busyNext   = BUSY_INIT;
                        w_latIdxNext = bus.wr_idx_i;
                        w_latWrNext  = bus.wr_en_i;
                    end
                end
                MULTI: begin
                    w_exStallNext = 1'b0;
                    w_busyNext    = r_busy - 4'd1;
                    if (r_busy <= 4'd1) begin
                        w_stateNext = IDLE;
                        w_latWrNext = 1'b0;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_busy    <= '0;
            r_exStall <= 1'b1;
            r_latIdx  <= '0;
            r_latWr   <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_busy    <= w_busyNext;
            r_exStall <= w_exStallNext;
            r_latIdx  <= w_latIdxNext;
            r_latWr   <= w_latWrNext;
        end
    end

    // Issue, retire and flush-release are summed per register; a retire of an empty
    // counter is ignored, and the floor at zero covers a release racing a retire.
    always_comb begin
        for (int r = 0; r < 16; r++) begin
            w_up[r]   = {1'b0, r_cnt[r]}
                      + (CNT_W+1)'(w_fire && bus.wr_en_i && (bus.wr_idx_i == 4'(r)));
            w_down[r] = (CNT_W+1)'(bus.wb_en_i && (bus.wb_idx_i == 4'(r)) && (r_cnt[r] != '0))
                      + (CNT_W+1)'(w_release && (r_latIdx == 4'(r)));
            w_cntNext[r] = (w_up[r] >= w_down[r]) ? CNT_W'(w_up[r] - w_down[r]) : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < 16; r++) begin
                r_cnt[r] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int r = 0; r < 16; r++) begin
                r_cnt[r] <= w_cntNext[r];
            end
            if (w_errSet) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_issue_ctrl.sv
// Self-checking bench for cpu_issue_ctrl: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the scoreboard and sequencer.
module tb_cpu_issue_ctrl;

    localparam int MULTI_LAT = 4;
    localparam int CNT_W     = 2;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cpu_issue_ctrl_if bus ();

    cpu_issue_ctrl #(.MULTI_LAT(MULTI_LAT), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clearInputs();
        bus.issue_valid_i = 1'b0;
        bus.rA_idx_i      = '0;
        bus.rA_use_i      = 1'b0;
        bus.rB_idx_i      = '0;
        bus.rB_use_i      = 1'b0;
        bus.wr_idx_i      = '0;
        bus.wr_en_i       = 1'b0;
        bus.multi_i       = 1'b0;
        bus.wb_en_i       = 1'b0;
        bus.wb_idx_i      = '0;
        bus.flush_i       = 1'b0;
    endtask

    task automatic offerWrite(input logic [3:0] idx, input logic multi);
        bus.issue_valid_i = 1'b1;
        bus.wr_en_i       = 1'b1;
        bus.wr_idx_i      = idx;
        bus.multi_i       = multi;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        clearInputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        resetDut();
        @(negedge clk);
        clearInputs();
        #1;
        checks++; if (bus.ex_stall_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ex_stall: got %b expected 1", bus.ex_stall_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err_o); end
        checks++; if (bus.pending_o !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pending: got %h expected 0000", bus.pending_o); end
        checks++; if (bus.issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.issue_ready_o); end
        checks++; if (bus.hazard_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_hazard: got %b expected 0", bus.hazard_o); end
    endtask

    task automatic test_issue_basic();
        @(negedge clk); clearInputs(); offerWrite(4'd3, 1'b0); #1;
        checks++; if (bus.fire_o !== 1'b1) begin errors++; $display("[TB] FAIL t1_fire: got %b expected 1", bus.fire_o); end
        @(negedge clk); clearInputs(); #1;
        checks++; if (bus.ex_stall_o !== 1'b0) begin errors++; $display("[TB] FAIL t1_stall_low: got %b expected 0", bus.ex_stall_o); end
        checks++; if (bus.pending_o !== 16'h0008) begin errors++; $display("[TB] FAIL t1_pending: got %h expected 0008", bus.pending_o); end
        @(negedge clk); #1;
        checks++; if (bus.ex_stall_o !== 1'b1) begin errors++; $display("[TB] FAIL t1_stall_back: got %b expected 1", bus.ex_stall_o); end
    endtask

    task automatic test_raw_hazard();
        @(negedge clk); clearInputs(); offerWrite(4'd4, 1'b0);
        bus.rA_use_i = 1'b1; bus.rA_idx_i = 4'd3; bus.wb_en_i = 1'b1; bus.wb_idx_i = 4'd3; #1;
        checks++; if (bus.hazard_o !== 1'b1) begin errors++; $display("[TB] FAIL t2_hazard: got %b expected 1", bus.hazard_o); end
        checks++; if (bus.issue_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL t2_ready: got %b expected 0", bus.issue_ready_o); end
        @(negedge clk); bus.wb_en_i = 1'b0; #1;
        checks++; if (bus.fire_o !== 1'b1) begin errors++; $display("[TB] FAIL t2_fire_after_wb: got %b expected 1", bus.fire_o); end
        checks++; if (bus.pending_o !== 16'h0000) begin errors++; $display("[TB] FAIL t2_pending_r3_clear: got %h expected 0000", bus.pending_o); end
        @(negedge clk); clearInputs(); bus.wb_en_i = 1'b1; bus.wb_idx_i = 4'd4; #1;
        checks++; if (bus.pending_o !== 16'h0010) begin errors++; $display("[TB] FAIL t2_pending_r4: got %h expected 0010", bus.pending_o); end
        @(negedge clk); clearInputs(); #1;
        checks++; if (bus.pending_o !== 16'h0000) begin errors++; $display("[TB] FAIL t2_pending_drained: got %h expected 0000", bus.pending_o); end
    endtask

    task automatic test_multi();
        @(negedge clk); clearInputs(); offerWrite(4'd5, 1'b1); #1;
        checks++; if (bus.fire_o !== 1'b1) begin errors++; $display("[TB] FAIL t3_fire: got %b expected 1", bus.fire_o); end
        for (int k = 1; k < MULTI_LAT; k++) begin
            @(negedge clk); clearInputs(); bus.issue_valid_i = 1'b1; #1;
            checks++; if (bus.issue_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL t3_ready_busy c%0d: got %b expected 0", k, bus.issue_ready_o); end
            checks++; if (bus.ex_stall_o !== 1'b0) begin errors++; $display("[TB] FAIL t3_stall_busy c%0d: got %b expected 0", k, bus.ex_stall_o); end
            checks++; if (bus.pending_o !== 16'h0020) begin errors++; $display("[TB] FAIL t3_pending c%0d: got %h expected 0020", k, bus.pending_o); end
        end
        @(negedge clk); clearInputs(); #1;
        checks++; if (bus.issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL t3_ready_done: got %b expected 1", bus.issue_ready_o); end
        checks++; if (bus.ex_stall_o !== 1'b0) begin errors++; $display("[TB] FAIL t3_stall_last: got %b expected 0", bus.ex_stall_o); end
        @(negedge clk); bus.wb_en_i = 1'b1; bus.wb_idx_i = 4'd5; #1;
        checks++; if (bus.ex_stall_o !== 1'b1) begin errors++; $display("[TB] FAIL t3_stall_idle: got %b expected 1", bus.ex_stall_o); end
        @(negedge clk); clearInputs(); #1;
        checks++; if (bus.pending_o !== 16'h0000) begin errors++; $display("[TB] FAIL t3_pending_drained: got %h expected 0000", bus.pending_o); end
    endtask

    task automatic test_waw_saturation();
        for (int i = 0; i < CNT_MAX; i++) begin
            @(negedge clk); clearInputs(); offerWrite(4'd1, 1'b0); #1;
            checks++; if (bus.fire_o !== 1'b1) begin errors++; $display("[TB] FAIL t4_fill%0d: got %b expected 1", i, bus.fire_o); end
        end
        @(negedge clk); clearInputs(); offerWrite(4'd1, 1'b0); #1;
        checks++; if (bus.hazard_o !== 1'b1) begin errors++; $display("[TB] FAIL t4_full_hazard: got %b expected 1", bus.hazard_o); end
        checks++; if (bus.pending_o !== 16'h0002) begin errors++; $display("[TB] FAIL t4_pending: got %h expected 0002", bus.pending_o); end
        // counter is full when the retire arrives, so this offer is still blocked
        @(negedge clk); bus.wb_en_i = 1'b1; bus.wb_idx_i = 4'd1; #1;
        checks++; if (bus.fire_o !== 1'b0) begin errors++; $display("[TB] FAIL t4_full_wb_fire: got %b expected 0", bus.fire_o); end
        @(negedge clk); #1;
        checks++; if (bus.fire_o !== 1'b1) begin errors++; $display("[TB] FAIL t4_wb_issue_fire: got %b expected 1", bus.fire_o); end
        @(negedge clk); bus.wb_en_i = 1'b0; #1;
        checks++; if (bus.fire_o !== 1'b1) begin errors++; $display("[TB] FAIL t4_net_unchanged: got %b expected 1", bus.fire_o); end
        @(negedge clk); #1;
        checks++; if (bus.hazard_o !== 1'b1) begin errors++; $display("[TB] FAIL t4_refull_hazard: got %b expected 1", bus.hazard_o); end
        clearInputs();
        repeat (CNT_MAX) begin
            @(negedge clk); bus.wb_en_i = 1'b1; bus.wb_idx_i = 4'd1;
        end
        @(negedge clk); clearInputs(); #1;
        checks++; if (bus.pending_o !== 16'h0000 || bus.err_o !== 1'b0) begin errors++; $display("[TB] FAIL t4_drain: got pending %h err %b expected 0000 0", bus.pending_o, bus.err_o); end
    endtask

    task automatic test_flush();
        @(negedge clk); clearInputs(); offerWrite(4'd7, 1'b1); #1;
        checks++; if (bus.fire_o !== 1'b1) begin errors++; $display("[TB] FAIL t5_fire: got %b expected 1", bus.fire_o); end
        @(negedge clk); clearInputs(); bus.issue_valid_i = 1'b1; #1;
        checks++; if (bus.pending_o !== 16'h0080) begin errors++; $display("[TB] FAIL t5_pending_set: got %h expected 0080", bus.pending_o); end
        @(negedge clk); bus.flush_i = 1'b1; #1;
        checks++; if (bus.fire_o !== 1'b0) begin errors++; $display("[TB] FAIL t5_no_fire_flush: got %b expected 0", bus.fire_o); end
        @(negedge clk); clearInputs(); #1;
        checks++; if (bus.ex_stall_o !== 1'b1) begin errors++; $display("[TB] FAIL t5_stall: got %b expected 1", bus.ex_stall_o); end
        checks++; if (bus.issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL t5_idle_ready: got %b expected 1", bus.issue_ready_o); end
        checks++; if (bus.pending_o !== 16'h0000) begin errors++; $display("[TB] FAIL t5_pending_released: got %h expected 0000", bus.pending_o); end
    endtask

    task automatic test_err_and_reset();
        @(negedge clk); clearInputs(); bus.wb_en_i = 1'b1; bus.wb_idx_i = 4'd9; #1;
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("[TB] FAIL t6_err_before: got %b expected 0", bus.err_o); end
        @(negedge clk); clearInputs(); #1;
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("[TB] FAIL t6_err_set: got %b expected 1", bus.err_o); end
        checks++; if (bus.pending_o !== 16'h0000) begin errors++; $display("[TB] FAIL t6_cnt_untouched: got %h expected 0000", bus.pending_o); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("[TB] FAIL t6_err_sticky: got %b expected 1", bus.err_o); end
        @(negedge clk); clearInputs(); offerWrite(4'd2, 1'b1); #1;
        @(negedge clk); clearInputs(); #1;
        checks++; if (bus.pending_o !== 16'h0004 || bus.ex_stall_o !== 1'b0) begin errors++; $display("[TB] FAIL t6_in_multi: got pending %h stall %b expected 0004 0", bus.pending_o, bus.ex_stall_o); end
        rst = 1'b1; #1;
        checks++; if (bus.ex_stall_o !== 1'b1 || bus.err_o !== 1'b0) begin errors++; $display("[TB] FAIL t6_async_reset: got stall %b err %b expected 1 0", bus.ex_stall_o, bus.err_o); end
        checks++; if (bus.pending_o !== 16'h0000 || bus.issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL t6_async_reset_comb: got pending %h ready %b expected 0000 1", bus.pending_o, bus.issue_ready_o); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_random();
        int         mCnt [16];
        int         mBusy;
        int         mLatIdx;
        bit         mLatWr;
        bit         mStall;
        bit         mErr;
        int         nxt;
        bit         v, raU, rbU, we, mu, wb, fl, hz, inMulti, eReady, eFire;
        int         ra, rb, wr, wbi;
        logic [15:0] ePend;
        resetDut();
        for (int r = 0; r < 16; r++) mCnt[r] = 0;
        mBusy = 0; mLatIdx = 0; mLatWr = 0; mStall = 1; mErr = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            v   = ($urandom_range(0, 9) < 7);
            raU = $urandom_range(0, 1); ra = $urandom_range(0, 7);
            rbU = $urandom_range(0, 1); rb = $urandom_range(0, 7);
            we  = ($urandom_range(0, 3) != 0); wr = $urandom_range(0, 7);
            mu  = ($urandom_range(0, 6) == 0);
            wb  = ($urandom_range(0, 9) < 5); wbi = $urandom_range(0, 7);
            fl  = ($urandom_range(0, 19) == 0);
            bus.issue_valid_i = v;  bus.rA_use_i = raU; bus.rA_idx_i = 4'(ra);
            bus.rB_use_i = rbU; bus.rB_idx_i = 4'(rb);
            bus.wr_en_i = we; bus.wr_idx_i = 4'(wr); bus.multi_i = mu;
            bus.wb_en_i = wb; bus.wb_idx_i = 4'(wbi); bus.flush_i = fl;
            #1;
            hz      = (raU && mCnt[ra] > 0) || (rbU && mCnt[rb] > 0) || (we && mCnt[wr] == CNT_MAX);
            inMulti = (mBusy > 0);
            eReady  = !inMulti && !hz && !fl;
            eFire   = v && eReady;
            ePend   = '0;
            for (int r = 0; r < 16; r++) ePend[r] = (mCnt[r] > 0);
            checks++; if (bus.issue_ready_o !== eReady) begin errors++; $display("[TB] FAIL rnd_ready c%0d: got %b expected %b", cyc, bus.issue_ready_o, eReady); end
            checks++; if (bus.fire_o !== eFire) begin errors++; $display("[TB] FAIL rnd_fire c%0d: got %b expected %b", cyc, bus.fire_o, eFire); end
            checks++; if (bus.hazard_o !== (v && hz)) begin errors++; $display("[TB] FAIL rnd_hazard c%0d: got %b expected %b", cyc, bus.hazard_o, v && hz); end
            checks++; if (bus.pending_o !== ePend) begin errors++; $display("[TB] FAIL rnd_pending c%0d: got %h expected %h", cyc, bus.pending_o, ePend); end
            checks++; if (bus.ex_stall_o !== mStall) begin errors++; $display("[TB] FAIL rnd_stall c%0d: got %b expected %b", cyc, bus.ex_stall_o, mStall); end
            checks++; if (bus.err_o !== mErr) begin errors++; $display("[TB] FAIL rnd_err c%0d: got %b expected %b", cyc, bus.err_o, mErr); end
            if (wb && mCnt[wbi] == 0) mErr = 1;
            for (int r = 0; r < 16; r++) begin
                nxt = mCnt[r];
                if (eFire && we && wr == r) nxt++;
                if (wb && wbi == r && mCnt[r] > 0) nxt--;
                if (fl && inMulti && mLatWr && mLatIdx == r) nxt--;
                mCnt[r] = (nxt < 0) ? 0 : nxt;
            end
            if (fl) begin
                mStall = 1; mBusy = 0; mLatWr = 0;
            end else if (inMulti) begin
                mStall = 0; mBusy--;
            end else begin
                mStall = !eFire;
                if (eFire && mu) begin
                    mBusy = MULTI_LAT - 1; mLatIdx = wr; mLatWr = we;
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clearInputs();
        test_reset();
        test_issue_basic();
        test_raw_hazard();
        test_multi();
        test_waw_saturation();
        test_flush();
        test_err_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
